// File: rtl/fifo_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ctrl : pointer and flag controller for a 2^AW-entry FIFO memory array.
//
// Holds the write/read pointers (AW address bits plus one wrap bit). It gates
// the write enable into the array and derives full/empty/threshold/occupancy
// from the pointers. It also reports rejected requests as overflow/underflow.
// Read data comes from the array combinationally at rptr, so the head word is
// visible before it is popped.
//
// Optional feature macro: FIFO_CTRL_STICKY_ERR_EN
//   defined   : overflow/underflow are sticky until an edge with err_clr=1
//               (a set event on the same edge wins over the clear).
//   undefined : overflow/underflow are one-cycle pulses; err_clr is ignored.
//
// Ports
//   clk            : clock, rising edge
//   rst_n          : asynchronous active-low reset
//   wr, rd         : write / pop requests
//   err_clr        : clears sticky error flags (sticky build only)
//   fifo_we        : write enable to the array (accepted write)
//   fifo_rd        : accepted-read strobe
//   wptr, rptr     : AW+1 bit pointers, bit AW is the wrap bit
//   fifo_full      : 2^AW entries held
//   fifo_empty     : no entries held
//   fifo_threshold : fifo_cnt >= THRESH
//   fifo_cnt       : occupancy 0..2^AW
//   fifo_overflow  : a write was rejected
//   fifo_underflow : a read was rejected
// -----------------------------------------------------------------------------
module fifo_ctrl #(
    parameter int AW     = 4,
    parameter int THRESH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr,
    input  logic        rd,
    input  logic        err_clr,
    output logic        fifo_we,
    output logic        fifo_rd,
    output logic [AW:0] wptr,
    output logic [AW:0] rptr,
    output logic        fifo_full,
    output logic        fifo_empty,
    output logic        fifo_threshold,
    output logic [AW:0] fifo_cnt,
    output logic        fifo_overflow,
    output logic        fifo_underflow
);

    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] THRESH_C = (AW+1)'(THRESH);
    localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);

    // Request/accept semantics: wr and rd are requests that may be held or
    // dropped at any time. A request is accepted (fifo_we / fifo_rd high) in a
    // cycle where the FIFO can honour it. Acceptance takes effect on the next
    // rising edge. A request made when it cannot be honoured is dropped and
    // reported as an error; it is never queued.

    // Derived controller state, kept as a register so the occupancy phase is
    // directly observable. The flags themselves are always taken from the
    // pointers, never from this register.
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [AW:0] wptr_q;
    logic [AW:0] rptr_q;
    logic        ovf_q;
    logic        unf_q;
    logic        ovf_evt;
    logic        unf_evt;

    // Flags come from the registered pointers only.
    assign fifo_empty     = (wptr_q == rptr_q);
    assign fifo_full      = (wptr_q[AW] != rptr_q[AW]) &&
                            (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign fifo_cnt       = wptr_q - rptr_q;
    assign fifo_threshold = (fifo_cnt >= THRESH_C);

    // Qualify with rst_n so the array sees no write while reset is held.
    // Full is judged before any same-cycle pop: no pass-through.
    assign fifo_we = rst_n & wr & ~fifo_full;
    assign fifo_rd = rst_n & rd & ~fifo_empty;

    assign ovf_evt = wr & fifo_full;
    assign unf_evt = rd & fifo_empty;

    assign wptr           = wptr_q;
    assign rptr           = rptr_q;
    assign fifo_overflow  = ovf_q;
    assign fifo_underflow = unf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (fifo_we) wptr_q <= wptr_q + PTR_ONE;
            if (fifo_rd) rptr_q <= rptr_q + PTR_ONE;
        end
    end

`ifdef FIFO_CTRL_STICKY_ERR_EN
    // Sticky: a set event on the same edge as err_clr wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_evt | (ovf_q & ~err_clr);
            unf_q <= unf_evt | (unf_q & ~err_clr);
        end
    end
`else
    // Pulse: high for the single cycle after the event edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_evt;
            unf_q <= unf_evt;
        end
    end

    // err_clr has no function in the pulse build.
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: begin
                // A simultaneous read is rejected here, so any write moves on.
                if (fifo_we) state_d = ST_PARTIAL;
            end
            ST_PARTIAL: begin
                if (fifo_we && !fifo_rd && fifo_cnt == CNT_LAST)
                    state_d = ST_FULL;
                else if (fifo_rd && !fifo_we && fifo_cnt == PTR_ONE)
                    state_d = ST_EMPTY;
            end
            ST_FULL: begin
                if (fifo_rd) state_d = ST_PARTIAL;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_ctrl : self-checking bench for fifo_ctrl (AW=4, THRESH=8).
// Reference model: a queue of written tokens plus running totals of accepted
// writes and reads; all expected pointers, flags and counts follow from those.
// -----------------------------------------------------------------------------
module tb_fifo_ctrl;

    localparam int AW     = 4;
    localparam int DEPTH  = 16;
    localparam int THRESH = 8;

    logic          clk;
    logic          rst_n;
    logic          wr;
    logic          rd;
    logic          err_clr;
    logic          fifo_we;
    logic          fifo_rd;
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_threshold;
    logic [AW:0]   fifo_cnt;
    logic          fifo_overflow;
    logic          fifo_underflow;

    fifo_ctrl #(.AW(AW), .THRESH(THRESH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr             (wr),
        .rd             (rd),
        .err_clr        (err_clr),
        .fifo_we        (fifo_we),
        .fifo_rd        (fifo_rd),
        .wptr           (wptr),
        .rptr           (rptr),
        .fifo_full      (fifo_full),
        .fifo_empty     (fifo_empty),
        .fifo_threshold (fifo_threshold),
        .fifo_cnt       (fifo_cnt),
        .fifo_overflow  (fifo_overflow),
        .fifo_underflow (fifo_underflow)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard / model ----------------
    logic [31:0] exp_q[$];    // tokens in FIFO order; token = write index
    int          wr_total;
    int          rd_total;
    bit          m_ovf;
    bit          m_unf;
    int          n_checks;
    int          n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        wr_total = 0;
        rd_total = 0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
    endtask

    task automatic check_all();
        int occ;
        occ = exp_q.size();
        check("wptr",      wptr,           wr_total % 32);
        check("rptr",      rptr,           rd_total % 32);
        check("cnt",       fifo_cnt,       occ);
        check("empty",     fifo_empty,     occ == 0);
        check("full",      fifo_full,      occ == DEPTH);
        check("threshold", fifo_threshold, occ >= THRESH);
        check("overflow",  fifo_overflow,  m_ovf);
        check("underflow", fifo_underflow, m_unf);
        if (occ > 0) check("head_addr", rptr[AW-1:0], exp_q[0] % DEPTH);
    endtask

    // ---------------- driver ----------------
    // One clock cycle: drive, check the combinational accepts, clock, check state.
    task automatic step(input bit w, input bit r, input bit ec);
        bit exp_we, exp_rd, ovf_evt, unf_evt;
        @(negedge clk);
        wr      = w;
        rd      = r;
        err_clr = ec;
        #1;
        exp_we  = w && (exp_q.size() < DEPTH);
        exp_rd  = r && (exp_q.size() > 0);
        ovf_evt = w && (exp_q.size() == DEPTH);
        unf_evt = r && (exp_q.size() == 0);
        check("fifo_we", fifo_we, exp_we);
        check("fifo_rd", fifo_rd, exp_rd);
        @(posedge clk);
        #1;
        if (exp_rd) begin
            void'(exp_q.pop_front());
            rd_total++;
        end
        if (exp_we) begin
            exp_q.push_back(wr_total);
            wr_total++;
        end
`ifdef FIFO_CTRL_STICKY_ERR_EN
        m_ovf = ovf_evt || (m_ovf && !ec);
        m_unf = unf_evt || (m_unf && !ec);
`else
        m_ovf = ovf_evt;
        m_unf = unf_evt;
`endif
        check_all();
    endtask

    // Asynchronous reset pulse placed between edges, with wr held high so a
    // write during reset would be visible.
    task automatic async_reset();
        @(negedge clk);
        wr = 1'b1;
        rd = 1'b0;
        err_clr = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check("rst_we", fifo_we, 0);
        check("rst_rd", fifo_rd, 0);
        @(posedge clk);
        #1;
        check_all();
        check("rst_we_edge", fifo_we, 0);
        @(negedge clk);
        wr = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) step(0, 1, 0);
    endtask

    task automatic random_run(input int n, input int p_wr, input int p_rd);
        for (int i = 0; i < n; i++)
            step($urandom_range(0, 99) < p_wr, $urandom_range(0, 99) < p_rd,
                 $urandom_range(0, 9) == 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        rst_n   = 1'b0;
        wr      = 1'b1;
        rd      = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        check("reset_we", fifo_we, 0);
        @(negedge clk);
        wr    = 1'b0;
        rst_n = 1'b1;

        // single write then single read
        step(1, 0, 0);
        step(0, 1, 0);

        // fill with 17 writes: 16 accepted, the 17th overflows
        for (int i = 0; i < 17; i++) step(1, 0, 0);
        step(0, 0, 0);   // overflow flag: pulse ends or sticky holds
        step(0, 0, 1);   // clear

        // drain and underflow
        drain();
        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 0, 1);

        // simultaneous requests at count 5, pointers wrap past 31
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        for (int i = 0; i < 40; i++) step(1, 1, 0);

        // simultaneous requests from full
        while (exp_q.size() < DEPTH) step(1, 0, 0);
        step(1, 1, 0);
        step(0, 0, 1);

        // simultaneous requests from empty
        drain();
        step(1, 1, 0);
        step(0, 0, 1);

        // overflow on the same edge as err_clr, then clear on the next edge
        while (exp_q.size() < DEPTH) step(1, 0, 0);
        step(1, 0, 1);
        step(0, 0, 1);

        // randomized traffic with varying bias
        random_run(150, 70, 30);
        random_run(150, 30, 70);
        random_run(150, 50, 50);

        // asynchronous reset at count 10
        drain();
        for (int i = 0; i < 10; i++) step(1, 0, 0);
        async_reset();
        step(1, 0, 0);
        random_run(100, 60, 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
